// File: rtl/cpu_phase_sequencer.sv
// Phase sequencer that produces the 3-bit timer code for the controller: fetch, execute, memory access and multi-cycle ALU waits, plus run/halt/step control.
// Optional macro SEQ_INSTR_CNT_EN adds a 16-bit retired-instruction counter with a synchronous clear.
module cpu_phase_sequencer #(
  parameter int ALU_MAX_CYCLES = 16,
  parameter int ALU_CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       mem_ready,
  input  logic [7:0] fetch_op,
  input  logic       alu_done,
  output logic [2:0] timer,
  output logic       alu_start,
  output logic       instr_done,
  output logic       halted,
  output logic       alu_timeout
`ifdef SEQ_INSTR_CNT_EN
  ,
  input  logic        clr_count,
  output logic [15:0] instr_count
`endif
);

  // State encodings equal the phase codes so timer is a straight copy of the state register.
  typedef enum logic [2:0] {
    S_INIT    = 3'b100,
    S_FETCH_A = 3'b000,
    S_FETCH_D = 3'b001,
    S_EXEC    = 3'b011,
    S_MEM_A   = 3'b101,
    S_MEM_D   = 3'b111
  } state_t;

  localparam logic [ALU_CNT_W-1:0] ALU_CNT_LAST = ALU_CNT_W'(ALU_MAX_CYCLES - 1);

  state_t               r_state;
  logic [7:0]           r_op;
  logic [ALU_CNT_W-1:0] r_cnt;
  logic                 r_one_shot;
  logic                 r_halted;
  logic                 r_timeout;

  state_t               w_next_state;
  logic                 w_finish;
  logic                 w_alu_start;
  logic                 w_muldiv;
  logic                 w_op_load;
  logic                 w_arm;
  logic                 w_timeout_set;
  logic [ALU_CNT_W-1:0] w_cnt_next;

  assign w_muldiv = (r_op == 8'h0F) || (r_op == 8'h10);

  always_comb begin
    w_next_state  = S_INIT;
    w_finish      = 1'b0;
    w_alu_start   = 1'b0;
    w_op_load     = 1'b0;
    w_arm         = 1'b0;
    w_timeout_set = 1'b0;
    w_cnt_next    = r_cnt;
    case (r_state)
      S_INIT: begin
        if (run || step) begin
          w_next_state = S_FETCH_A;
          w_arm        = step && !run;
        end else begin
          w_next_state = S_INIT;
        end
      end
      S_FETCH_A: w_next_state = S_FETCH_D;
      S_FETCH_D: begin
        if (mem_ready) begin
          w_op_load    = 1'b1;
          w_next_state = (fetch_op[7:2] == 6'b100000) ? S_MEM_A : S_EXEC;
        end else begin
          w_next_state = S_FETCH_D;
        end
      end
      S_EXEC: begin
        if (!w_muldiv) begin
          w_finish = 1'b1;
        end else begin
          // The counter is zero only in the first EXEC cycle of an instruction.
          w_alu_start = (r_cnt == '0);
          if (alu_done) begin
            w_finish = 1'b1;
          end else if (r_cnt == ALU_CNT_LAST) begin
            w_finish      = 1'b1;
            w_timeout_set = 1'b1;
          end else begin
            w_cnt_next   = r_cnt + 1'b1;
            w_next_state = S_EXEC;
          end
        end
      end
      S_MEM_A: w_next_state = S_MEM_D;
      S_MEM_D: begin
        if (mem_ready) w_finish = 1'b1;
        else           w_next_state = S_MEM_D;
      end
      default: w_next_state = S_INIT;
    endcase
    if (w_finish) begin
      w_cnt_next   = '0;
      w_next_state = (run && !r_one_shot) ? S_FETCH_A : S_INIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_INIT;
      r_op       <= 8'h00;
      r_cnt      <= '0;
      r_one_shot <= 1'b0;
      r_halted   <= 1'b1;
      r_timeout  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_halted <= (w_next_state == S_INIT);
      if (w_op_load)     r_op      <= fetch_op;
      if (w_timeout_set) r_timeout <= 1'b1;
      if (w_arm)         r_one_shot <= 1'b1;
      else if (w_finish) r_one_shot <= 1'b0;
    end
  end

`ifdef SEQ_INSTR_CNT_EN
  logic [15:0] r_instr_count;

  // Clear wins over a coincident retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_instr_count <= 16'h0000;
    else if (clr_count)  r_instr_count <= 16'h0000;
    else if (w_finish)   r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`endif

  assign timer       = r_state;
  assign alu_start   = w_alu_start;
  assign instr_done  = w_finish;
  assign halted      = r_halted;
  assign alu_timeout = r_timeout;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed instructions with hand-computed per-instruction results checked on instr_done.
module tb_cpu_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       mem_ready = 1'b0;
  logic       alu_done = 1'b0;
  logic [7:0] fetch_op = 8'h00;
  logic [2:0] timer;
  logic       alu_start;
  logic       instr_done;
  logic       halted;
  logic       alu_timeout;
`ifdef SEQ_INSTR_CNT_EN
  logic        clr_count = 1'b0;
  logic [15:0] instr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_cnt    = 0;
  int cfg_fw   = 0;
  int cfg_mw   = 0;
  int cfg_alu  = 0;

  // Expected word: {last phase[2:0], cycles[7:0], alu_timeout, alu_start pulses[3:0]}
  logic [15:0] exp_q[$];

  cpu_phase_sequencer #(.ALU_MAX_CYCLES(16), .ALU_CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .mem_ready   (mem_ready),
    .fetch_op    (fetch_op),
    .alu_done    (alu_done),
    .timer       (timer),
    .alu_start   (alu_start),
    .instr_done  (instr_done),
    .halted      (halted),
    .alu_timeout (alu_timeout)
`ifdef SEQ_INSTR_CNT_EN
    ,
    .clr_count   (clr_count),
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] ph, input int cyc, input logic to, input int st);
    return {ph, 8'(cyc), to, 4'(st)};
  endfunction

  // Memory/ALU responder: waits cfg_fw/cfg_mw cycles before mem_ready, alu_done in EXEC cycle cfg_alu (0 = never).
  logic [2:0] rsp_prev = 3'b100;
  int         rsp_cnt  = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (timer != rsp_prev) rsp_cnt = 0;
    else                   rsp_cnt++;
    rsp_prev  = timer;
    mem_ready = ((timer == 3'b001) && (rsp_cnt >= cfg_fw)) ||
                ((timer == 3'b111) && (rsp_cnt >= cfg_mw));
    alu_done  = (timer == 3'b011) && (cfg_alu != 0) && (rsp_cnt >= cfg_alu - 1);
  end

  // Monitor: measures each instruction and compares with the scoreboard on instr_done.
  int          mon_cyc    = 0;
  int          mon_starts = 0;
  logic [15:0] mon_act;
  logic [15:0] mon_exp;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_cyc    = 0;
      mon_starts = 0;
      n_cnt      = 0;
    end else begin
      if (timer == 3'b000) begin
        mon_cyc    = 1;
        mon_starts = 0;
      end else if (timer != 3'b100) begin
        mon_cyc++;
      end
      if (alu_start) mon_starts++;
      check("halted_vs_init", 32'(halted), 32'(timer == 3'b100));
      if (instr_done) begin
        n_done++;
        n_cnt++;
        mon_act = mk(timer, mon_cyc, alu_timeout, mon_starts);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr_done: got result 0x%0h, expected no instruction", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check("instr_result", 32'(mon_act), 32'(mon_exp));
        end
      end
    end
  end

  task automatic wait_phase(input logic [2:0] ph);
    int g = 0;
    while (timer != ph && g < 100) begin
      tick();
      g++;
    end
    check("reach_phase", 32'(timer), 32'(ph));
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (n_done < target && g < 200) begin
      tick();
      g++;
    end
    check("instr_completed", n_done, target);
  endtask

  task automatic issue(input logic [7:0] op, input int fw, input int mw, input int alu, input logic [15:0] e);
    fetch_op = op;
    cfg_fw   = fw;
    cfg_mw   = mw;
    cfg_alu  = alu;
    exp_q.push_back(e);
  endtask

  task automatic run_vec(input logic [7:0] op, input int fw, input int mw, input int alu,
                         input logic [2:0] ph, input int cyc, input logic to, input int st);
    int target;
    wait_phase(3'b000);
    target = n_done + 1;
    issue(op, fw, mw, alu, mk(ph, cyc, to, st));
    wait_done(target);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic idle_check(input int n, input int done_ref);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_timer", 32'(timer), 32'(3'b100));
      check("idle_halted", 32'(halted), 32'd1);
    end
    check("idle_no_instr", n_done, done_ref);
  endtask

  initial begin
    int target;
    reset    = 1'b0;
    run      = 1'b1;
    fetch_op = 8'h00;
    @(negedge clk);
    check("rst_timer", 32'(timer), 32'(3'b100));
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_alu_timeout", 32'(alu_timeout), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("release_timer", 32'(timer), 32'(3'b100));
    check("release_halted", 32'(halted), 32'd1);
    @(negedge clk);
    check("first_fetch_timer", 32'(timer), 32'(3'b000));
    check("first_fetch_halted", 32'(halted), 32'd0);

    //       op     fw mw alu  phase   cyc to  starts
    run_vec(8'h00, 0, 0, 0,  3'b011, 3,  0, 0);
    run_vec(8'h00, 2, 0, 0,  3'b011, 5,  0, 0);
    run_vec(8'h82, 0, 3, 0,  3'b111, 7,  0, 0);
    run_vec(8'h80, 1, 1, 0,  3'b111, 6,  0, 0);
    run_vec(8'h83, 0, 0, 0,  3'b111, 4,  0, 0);
    run_vec(8'h84, 0, 0, 0,  3'b011, 3,  0, 0);
    run_vec(8'h7F, 0, 0, 0,  3'b011, 3,  0, 0);
    run_vec(8'h0F, 0, 0, 5,  3'b011, 7,  0, 1);
    run_vec(8'h10, 0, 0, 1,  3'b011, 3,  0, 1);
    run_vec(8'h0F, 0, 0, 16, 3'b011, 18, 0, 1);
    run_vec(8'h10, 0, 0, 0,  3'b011, 18, 0, 1);
    run_vec(8'h00, 0, 0, 0,  3'b011, 3,  1, 0);
    check("timeout_sticky", 32'(alu_timeout), 32'd1);

    // Dropping run mid-instruction lets it complete, then parks.
    wait_phase(3'b000);
    target = n_done + 1;
    issue(8'h00, 1, 0, 0, mk(3'b011, 4, 1'b1, 0));
    run = 1'b0;
    wait_done(target);
    idle_check(4, target);

    target = n_done + 1;
    issue(8'h00, 0, 0, 0, mk(3'b011, 3, 1'b1, 0));
    pulse_step();
    wait_done(target);
    idle_check(3, target);

    target = n_done + 1;
    issue(8'h82, 0, 0, 0, mk(3'b111, 4, 1'b1, 0));
    pulse_step();
    wait_done(target);
    idle_check(3, target);

    target = n_done + 1;
    issue(8'h0F, 0, 0, 3, mk(3'b011, 5, 1'b1, 1));
    pulse_step();
    wait_phase(3'b011);
    pulse_step();
    wait_done(target);
    idle_check(4, target);

    // Asynchronous reset in the middle of a memory wait.
    issue(8'h82, 0, 5, 0, 16'h0000);
    exp_q.delete();
    run = 1'b1;
    wait_phase(3'b111);
    tick();
    check("pre_reset_timer", 32'(timer), 32'(3'b111));
    check("pre_reset_timeout", 32'(alu_timeout), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_timer", 32'(timer), 32'(3'b100));
    check("async_rst_halted", 32'(halted), 32'd1);
    check("async_rst_timeout", 32'(alu_timeout), 32'd0);
    check("async_rst_instr_done", 32'(instr_done), 32'd0);
    tick();
    tick();
    cfg_mw   = 0;
    fetch_op = 8'h00;
    reset    = 1'b1;
    wait_phase(3'b000);
    target = n_done + 1;
    issue(8'h00, 0, 0, 0, mk(3'b011, 3, 1'b0, 0));
    run = 1'b0;
    wait_done(target);
    idle_check(2, target);

`ifdef SEQ_INSTR_CNT_EN
    check("instr_count", 32'(instr_count), 32'(n_cnt & 16'hFFFF));
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("instr_count_clr", 32'(instr_count), 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
